// File: rtl/linear_sorter_pkg.sv
// Shared constants and types for the linear sorter chain and its drain stage.
package linear_sorter_pkg;

    localparam int SORTER_NUM_CELLS = 8;
    localparam int SORTER_DATA_W    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } drain_state_t;

    typedef logic [SORTER_DATA_W-1:0] cell_word_t;

endpackage

// File: rtl/sorter_fill_count.sv
// Leading-ones count of ~cell_empty_i: the number of contiguously filled cells from cell 0.
module sorter_fill_count #(
    parameter int NUM_CELLS = 8
) (
    input  logic [NUM_CELLS-1:0]             cell_empty_i,
    output logic [$clog2(NUM_CELLS+1)-1:0]   count
);

    localparam int CNT_W = $clog2(NUM_CELLS+1);

    logic found;

    // Cells beyond the first empty one are ignored even if they report data.
    always_comb begin
        count = CNT_W'(NUM_CELLS);
        found = 1'b0;
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (!found && cell_empty_i[k]) begin
                count = CNT_W'(k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/linear_sorter_drain.sv
// Drain stage: snapshots the sorter chain, clears it, then streams the sorted words out.
// Optional adjacent-order checker enabled by defining LINEAR_SORTER_ORDER_CHECK_EN.
module linear_sorter_drain
    import linear_sorter_pkg::*;
#(
    parameter int NUM_CELLS = SORTER_NUM_CELLS,
    parameter int DATA_W    = SORTER_DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_CELLS*DATA_W-1:0] cell_data_i,
    input  logic [NUM_CELLS-1:0]        cell_empty_i,
    output logic                        cells_clear,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    output logic                        done,
    output logic                        order_err
);

    localparam int CNT_W = $clog2(NUM_CELLS+1);

    drain_state_t      state_reg, state_next;
    logic [DATA_W-1:0] cell_word [NUM_CELLS];
    logic [DATA_W-1:0] snap_reg  [NUM_CELLS];
    logic [CNT_W-1:0]  fill_count;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  idx_reg, idx_next;
    logic [CNT_W-1:0]  idx_inc, count_m1, sel_idx;
    logic [DATA_W-1:0] sel_word;
    logic              capture, accept;

    logic              cells_clear_reg, cells_clear_next;
    logic              busy_reg, busy_next;
    logic              out_valid_reg, out_valid_next;
    logic [DATA_W-1:0] out_data_reg, out_data_next;
    logic              out_last_reg, out_last_next;
    logic              done_reg, done_next;

    assign capture  = (state_reg == IDLE) && start;
    assign accept   = out_valid_reg && out_ready;
    assign idx_inc  = idx_reg + CNT_W'(1);
    assign count_m1 = count_reg - CNT_W'(1);

    sorter_fill_count #(
        .NUM_CELLS (NUM_CELLS)
    ) u_fill_count (
        .cell_empty_i (cell_empty_i),
        .count        (fill_count)
    );

    // Snapshot is taken only on the capture edge; the chain is free afterwards.
    for (genvar gi = 0; gi < NUM_CELLS; gi++) begin : g_snap
        assign cell_word[gi] = cell_data_i[gi*DATA_W +: DATA_W];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                snap_reg[gi] <= '0;
            end else if (capture) begin
                snap_reg[gi] <= cell_word[gi];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            count_reg       <= '0;
            idx_reg         <= '0;
            cells_clear_reg <= 1'b0;
            busy_reg        <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_data_reg    <= '0;
            out_last_reg    <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= capture ? fill_count : count_reg;
            idx_reg         <= idx_next;
            cells_clear_reg <= cells_clear_next;
            busy_reg        <= busy_next;
            out_valid_reg   <= out_valid_next;
            out_data_reg    <= out_data_next;
            out_last_reg    <= out_last_next;
            done_reg        <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CLEAR;
            CLEAR:   state_next = (count_reg == '0) ? DONE : STREAM;
            STREAM:  if (accept && out_last_reg) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Word to present next: cell 0 when entering STREAM, idx+1 after a handshake.
    assign sel_idx = (state_reg == STREAM) ? idx_inc : '0;

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (sel_idx == CNT_W'(k)) sel_word = snap_reg[k];
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        cells_clear_next = capture;
        busy_next        = (state_next != IDLE);
        out_valid_next   = (state_next == STREAM);
        done_next        = (state_next == DONE);
        idx_next         = idx_reg;
        out_data_next    = out_data_reg;
        out_last_next    = out_last_reg;
        case (state_reg)
            IDLE: idx_next = '0;
            CLEAR: begin
                idx_next = '0;
                if (count_reg != '0) begin
                    out_data_next = sel_word;
                    out_last_next = (count_m1 == '0);
                end
            end
            STREAM: begin
                if (accept) begin
                    if (out_last_reg) begin
                        out_last_next = 1'b0;
                    end else begin
                        idx_next      = idx_inc;
                        out_data_next = sel_word;
                        out_last_next = (idx_inc == count_m1);
                    end
                end
            end
            default: ;
        endcase
    end

    assign cells_clear = cells_clear_reg;
    assign busy        = busy_reg;
    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;
    assign out_last    = out_last_reg;
    assign done        = done_reg;

`ifdef LINEAR_SORTER_ORDER_CHECK_EN
    logic order_bad;
    logic order_err_reg;

    always_comb begin
        order_bad = 1'b0;
        for (int k = 0; k < NUM_CELLS-1; k++) begin
            if ((CNT_W'(k+1) < count_reg) && (snap_reg[k] > snap_reg[k+1])) order_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            order_err_reg <= 1'b0;
        end else if ((state_reg == CLEAR) && order_bad) begin
            order_err_reg <= 1'b1;
        end
    end

    assign order_err = order_err_reg;

    assert property (@(posedge clk) disable iff (reset) !((state_reg == CLEAR) && order_bad))
        else $error("linear_sorter_drain: captured cells are not in ascending order");
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: doc/linear_sorter_drain.md
Name: linear_sorter_drain

Overview:
- Downstream stage of the linear sorter cell chain.
- On a start request it snapshots every cell's data and empty flag in one cycle, then pulses a clear to the chain so the chain can load the next batch.
- It then streams the captured values out in ascending order (cell 0 first) over a valid/ready interface.
- Cell 0 holds the minimum; each later cell holds a value greater than or equal to the one before it.

Parameters:
- NUM_CELLS, 8, number of sorter cells in the chain (range 2..64).
- DATA_W, 8, width of each cell value.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  capture request; sampled only in IDLE.
- cell_data_i  input  NUM_CELLS*DATA_W  concatenated cell values; cell k occupies bits [k*DATA_W +: DATA_W].
- cell_empty_i  input  NUM_CELLS  per-cell empty flag, 1 = cell holds no data.
- cells_clear  output  1  one-cycle pulse to reset/empty the cell chain.
- busy  output  1  high in every state except IDLE.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the current word.
- out_data  output  DATA_W  current sorted value.
- out_last  output  1  high together with out_valid on the final word.
- done  output  1  one-cycle pulse when a batch completes.
- order_err  output  1  sticky order-violation flag (see Optional Feature).

Behaviour:
- Reset: state=IDLE; cells_clear=0, busy=0, out_valid=0, out_data=0, out_last=0, done=0, order_err=0; snapshot registers and index cleared.
- States: IDLE, CLEAR, STREAM, DONE.
- IDLE:
  - On a clk edge with start=1, latch cell_data_i into the snapshot array.
  - Latch count = number of leading non-empty cells: index of the first cell with empty=1, or NUM_CELLS if none is empty.
  - Go to CLEAR.
- Non-contiguous fill: cells after the first empty cell are ignored, even if they are not empty.
- CLEAR:
  - cells_clear=1 for exactly this one cycle.
  - If count=0, go to DONE; otherwise set idx=0 and go to STREAM.
- STREAM:
  - out_valid=1, out_data=snapshot[idx], out_last=(idx==count-1).
  - On a clk edge with out_valid && out_ready:
    - if out_last, go to DONE;
    - otherwise idx increments.
  - With out_ready=0, out_data and out_last stay stable.
- DONE: done=1 for one cycle, then return to IDLE.
- Latency:
  - First out_valid asserts 2 cycles after the start edge.
  - Full batch with out_ready held high: 2 + count + 1 cycles from start to IDLE.
- start while busy=1 is ignored, with no queuing.
- Index width is $clog2(NUM_CELLS+1).
- Outputs out_valid, out_data, out_last, cells_clear, done and busy are all driven from registers.
- Reset mid-operation returns immediately to IDLE. The snapshot is discarded and no done is generated.
- cell_data_i is not sampled after the capture edge. Chain activity during STREAM does not affect the output.

Optional Feature:
- Macro: LINEAR_SORTER_ORDER_CHECK_EN.
- Enabled:
  - In CLEAR, each adjacent pair within count is compared.
  - order_err is set if snapshot[k] > snapshot[k+1] for any k < count-1.
  - order_err stays set until reset.
  - The $error assertion fires in simulation.
- Disabled: order_err is tied to 0 and no comparator logic is built.

Decomposition:
- Package linear_sorter_pkg holds:
  - default constants SORTER_NUM_CELLS=8 and SORTER_DATA_W=8;
  - the enum drain_state_t {IDLE, CLEAR, STREAM, DONE};
  - a typedef cell_word_t = logic [SORTER_DATA_W-1:0].
- Sub-module sorter_fill_count: combinational leading-ones count of ~cell_empty_i, producing count. It is reusable by the input controller.

Test Plan:
- Full batch: cells = 3,7,9,12,20,33,40,255, none empty, out_ready=1.
  - Expect out_data sequence 3,7,9,12,20,33,40,255.
  - out_last on 255; done 1 cycle later; cells_clear pulsed once.
- Partial batch: cells 0..2 = 5,5,6 and cells 3..7 empty.
  - Expect exactly 3 words 5,5,6, with out_last on 6.
- Empty chain: all cell_empty_i=1, start.
  - Expect cells_clear, then done; out_valid never asserted.
- Backpressure: 4-cell batch 1,2,3,4; out_ready toggles 0,0,1,0,1,1,0,1.
  - out_data holds while not ready; every value is delivered exactly once, in order.
- Start during STREAM, and reset mid-stream after word 2:
  - the second start is ignored;
  - after reset, out_valid=0, busy=0, no done; the next start captures fresh data.
- With LINEAR_SORTER_ORDER_CHECK_EN, cells 4,9,6,10:
  - order_err goes to 1 in the cycle after CLEAR and stays high until reset;
  - data still streams as 4,9,6,10.
